spring_scheduler: RTL and testbench

- Sequences one shared spring-force datapath (F = -k*dx - b*dv per axis) over a table of NUM_SPRINGS node-index pairs.
- Accumulates the resulting forces into per-node force registers: node A receives +F, node B receives -F.
- Sits between the node state store (positions/velocities) and the integrator stage.
- Runs one full pass over the spring table per start pulse.

---
 rtl/spring_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_spring_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spring_scheduler.sv
// spring_scheduler: walks the spring table once per start pulse, feeds each
// valid node pair to the shared spring-force datapath and accumulates the
// returned force into per-node registers (+F on node A, -F on node B).
// Optional build macro: SPRING_FORCE_SAT_EN (saturating accumulators; when
// undefined the accumulators wrap in two's complement).
module spring_scheduler #(
    parameter int NUM_SPRINGS   = 10,
    parameter int NUM_NODES     = 10,
    parameter int POSITION_SIZE = 8,
    parameter int VELOCITY_SIZE = 8,
    parameter int FORCE_SIZE    = 8,
    parameter int IDX_W         = $clog2(NUM_NODES),
    parameter int ADDR_W        = (NUM_SPRINGS > 1) ? $clog2(NUM_SPRINGS) : 1
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              idx_err,
    output logic [ADDR_W-1:0]                 tbl_addr,
    input  logic [IDX_W-1:0]                  tbl_a,
    input  logic [IDX_W-1:0]                  tbl_b,
    input  logic [NUM_NODES*POSITION_SIZE-1:0] pos_x_flat,
    input  logic [NUM_NODES*POSITION_SIZE-1:0] pos_y_flat,
    input  logic [NUM_NODES*VELOCITY_SIZE-1:0] vel_x_flat,
    input  logic [NUM_NODES*VELOCITY_SIZE-1:0] vel_y_flat,
    output logic                              sp_in_valid,
    output logic [2*POSITION_SIZE-1:0]        sp_p1,
    output logic [2*POSITION_SIZE-1:0]        sp_p2,
    output logic [2*VELOCITY_SIZE-1:0]        sp_v1,
    output logic [2*VELOCITY_SIZE-1:0]        sp_v2,
    input  logic                              sp_out_valid,
    input  logic [FORCE_SIZE-1:0]             sp_fx,
    input  logic [FORCE_SIZE-1:0]             sp_fy,
    output logic [NUM_NODES*FORCE_SIZE-1:0]   force_x_flat,
    output logic [NUM_NODES*FORCE_SIZE-1:0]   force_y_flat
);

    localparam logic [IDX_W:0]    NODE_LIMIT = (IDX_W+1)'(NUM_NODES);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_SPRINGS - 1);

`ifdef SPRING_FORCE_SAT_EN
    // One guard bit lets the saturation logic see the true sum sign.
    localparam int SUM_W = FORCE_SIZE + 1;
    localparam logic [FORCE_SIZE-1:0] F_MAX = {1'b0, {(FORCE_SIZE-1){1'b1}}};
    localparam logic [FORCE_SIZE-1:0] F_MIN = {1'b1, {(FORCE_SIZE-1){1'b0}}};
`else
    // Wrapping only keeps the low FORCE_SIZE bits, so the guard bit is dropped.
    localparam int SUM_W = FORCE_SIZE;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_READ, S_ISSUE, S_WAIT, S_ACCUM, S_DONE
    } state_t;

    // Sign-extend an accumulator/force operand to the working sum width.
    function automatic logic [SUM_W-1:0] sext_force(input logic [FORCE_SIZE-1:0] v);
`ifdef SPRING_FORCE_SAT_EN
        sext_force = {v[FORCE_SIZE-1], v};
`else
        sext_force = v;
`endif
    endfunction

    // Bring a working sum back to FORCE_SIZE (clamp or wrap).
    function automatic logic [FORCE_SIZE-1:0] fit_force(input logic [SUM_W-1:0] v);
`ifdef SPRING_FORCE_SAT_EN
        if (v[SUM_W-1] != v[SUM_W-2]) begin
            if (v[SUM_W-1]) fit_force = F_MIN;
            else            fit_force = F_MAX;
        end else begin
            fit_force = v[FORCE_SIZE-1:0];
        end
`else
        fit_force = v;
`endif
    endfunction

    state_t                  state_r, state_next_s;
    logic [ADDR_W-1:0]       i_r;
    logic [IDX_W-1:0]        a_r, b_r;
    logic [FORCE_SIZE-1:0]   fx_r, fy_r;
    logic [FORCE_SIZE-1:0]   acc_x_r [NUM_NODES];
    logic [FORCE_SIZE-1:0]   acc_y_r [NUM_NODES];
    logic                    busy_r, done_r, sp_in_valid_r, idx_err_r;
    logic [2*POSITION_SIZE-1:0] sp_p1_r, sp_p2_r;
    logic [2*VELOCITY_SIZE-1:0] sp_v1_r, sp_v2_r;
    logic                    bad_idx_s, same_idx_s, last_s;
    logic [SUM_W-1:0]        ax_s, ay_s, bx_s, by_s;

    // Classify the table entry being read and detect the last spring.
    always_comb begin
        bad_idx_s  = ({1'b0, tbl_a} >= NODE_LIMIT) || ({1'b0, tbl_b} >= NODE_LIMIT);
        same_idx_s = (tbl_a == tbl_b);
        last_s     = (i_r == LAST_IDX);
    end

    // Candidate accumulator values: node A gains F, node B loses F.
    always_comb begin
        ax_s = sext_force(acc_x_r[a_r]) + sext_force(fx_r);
        ay_s = sext_force(acc_y_r[a_r]) + sext_force(fy_r);
        bx_s = sext_force(acc_x_r[b_r]) - sext_force(fx_r);
        by_s = sext_force(acc_y_r[b_r]) - sext_force(fy_r);
    end

    // Next-state logic for the pass sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE:  begin
                if (start) state_next_s = S_CLEAR;
                else       state_next_s = S_IDLE;
            end
            S_CLEAR: state_next_s = S_FETCH;
            S_FETCH: state_next_s = S_READ;
            S_READ:  begin
                if (bad_idx_s || same_idx_s) begin
                    if (last_s) state_next_s = S_DONE;
                    else        state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_ISSUE;
                end
            end
            S_ISSUE: state_next_s = S_WAIT;
            S_WAIT:  begin
                if (sp_out_valid) state_next_s = S_ACCUM;
                else              state_next_s = S_WAIT;
            end
            S_ACCUM: begin
                if (last_s) state_next_s = S_DONE;
                else        state_next_s = S_FETCH;
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State, counter, operand, status and accumulator registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r       <= S_IDLE;
            i_r           <= '0;
            a_r           <= '0;
            b_r           <= '0;
            fx_r          <= '0;
            fy_r          <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            sp_in_valid_r <= 1'b0;
            idx_err_r     <= 1'b0;
            sp_p1_r       <= '0;
            sp_p2_r       <= '0;
            sp_v1_r       <= '0;
            sp_v2_r       <= '0;
            for (int n = 0; n < NUM_NODES; n++) begin
                acc_x_r[n] <= '0;
                acc_y_r[n] <= '0;
            end
        end else begin
            state_r       <= state_next_s;
            busy_r        <= (state_next_s != S_IDLE) && (state_next_s != S_DONE);
            done_r        <= (state_next_s == S_DONE);
            sp_in_valid_r <= (state_next_s == S_ISSUE);
            case (state_r)
                S_CLEAR: begin
                    i_r       <= '0;
                    idx_err_r <= 1'b0;
                    for (int n = 0; n < NUM_NODES; n++) begin
                        acc_x_r[n] <= '0;
                        acc_y_r[n] <= '0;
                    end
                end
                S_READ: begin
                    a_r <= tbl_a;
                    b_r <= tbl_b;
                    if (bad_idx_s || same_idx_s) begin
                        if (bad_idx_s) idx_err_r <= 1'b1;
                        if (!last_s)   i_r <= i_r + 1'b1;
                    end else begin
                        sp_p1_r <= {pos_y_flat[tbl_a*POSITION_SIZE +: POSITION_SIZE],
                                    pos_x_flat[tbl_a*POSITION_SIZE +: POSITION_SIZE]};
                        sp_p2_r <= {pos_y_flat[tbl_b*POSITION_SIZE +: POSITION_SIZE],
                                    pos_x_flat[tbl_b*POSITION_SIZE +: POSITION_SIZE]};
                        sp_v1_r <= {vel_y_flat[tbl_a*VELOCITY_SIZE +: VELOCITY_SIZE],
                                    vel_x_flat[tbl_a*VELOCITY_SIZE +: VELOCITY_SIZE]};
                        sp_v2_r <= {vel_y_flat[tbl_b*VELOCITY_SIZE +: VELOCITY_SIZE],
                                    vel_x_flat[tbl_b*VELOCITY_SIZE +: VELOCITY_SIZE]};
                    end
                end
                S_WAIT: begin
                    if (sp_out_valid) begin
                        fx_r <= sp_fx;
                        fy_r <= sp_fy;
                    end
                end
                S_ACCUM: begin
                    acc_x_r[a_r] <= fit_force(ax_s);
                    acc_y_r[a_r] <= fit_force(ay_s);
                    acc_x_r[b_r] <= fit_force(bx_s);
                    acc_y_r[b_r] <= fit_force(by_s);
                    if (!last_s) i_r <= i_r + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign idx_err     = idx_err_r;
    assign tbl_addr    = i_r;
    assign sp_in_valid = sp_in_valid_r;
    assign sp_p1       = sp_p1_r;
    assign sp_p2       = sp_p2_r;
    assign sp_v1       = sp_v1_r;
    assign sp_v2       = sp_v2_r;

    for (genvar n = 0; n < NUM_NODES; n++) begin : g_flat
        assign force_x_flat[n*FORCE_SIZE +: FORCE_SIZE] = acc_x_r[n];
        assign force_y_flat[n*FORCE_SIZE +: FORCE_SIZE] = acc_y_r[n];
    end

endmodule

// File: tb/tb_spring_scheduler.sv
// Directed bench for spring_scheduler: a registered spring-table memory and a
// force-datapath responder with programmable latency surround the DUT.
module tb_spring_scheduler;

    localparam int NS = 3;
    localparam int NN = 10;
    localparam int PS = 8;
    localparam int VS = 8;
    localparam int FS = 8;
    localparam int IW = 4;
    localparam int AW = 2;

    logic clk_in = 1'b0;
    logic rst_in, start;
    logic busy, done, idx_err, sp_in_valid, sp_out_valid;
    logic [AW-1:0] tbl_addr;
    logic [IW-1:0] tbl_a, tbl_b;
    logic [NN*PS-1:0] pos_x_flat, pos_y_flat;
    logic [NN*VS-1:0] vel_x_flat, vel_y_flat;
    logic [2*PS-1:0] sp_p1, sp_p2;
    logic [2*VS-1:0] sp_v1, sp_v2;
    logic [FS-1:0] sp_fx, sp_fy;
    logic [NN*FS-1:0] force_x_flat, force_y_flat;

    always #5 clk_in = ~clk_in;

    spring_scheduler #(
        .NUM_SPRINGS(NS), .NUM_NODES(NN), .POSITION_SIZE(PS),
        .VELOCITY_SIZE(VS), .FORCE_SIZE(FS), .IDX_W(IW)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start(start), .busy(busy),
        .done(done), .idx_err(idx_err), .tbl_addr(tbl_addr),
        .tbl_a(tbl_a), .tbl_b(tbl_b),
        .pos_x_flat(pos_x_flat), .pos_y_flat(pos_y_flat),
        .vel_x_flat(vel_x_flat), .vel_y_flat(vel_y_flat),
        .sp_in_valid(sp_in_valid), .sp_p1(sp_p1), .sp_p2(sp_p2),
        .sp_v1(sp_v1), .sp_v2(sp_v2), .sp_out_valid(sp_out_valid),
        .sp_fx(sp_fx), .sp_fy(sp_fy),
        .force_x_flat(force_x_flat), .force_y_flat(force_y_flat)
    );

    // Spring table contents and per-entry datapath responses.
    logic [IW-1:0] tab_a [0:3];
    logic [IW-1:0] tab_b [0:3];
    logic [FS-1:0] resp_fx [0:3];
    logic [FS-1:0] resp_fy [0:3];
    int ack_delay = 1;

    // Synchronous table memory: data valid one cycle after the address.
    always @(posedge clk_in) begin
        tbl_a <= tab_a[tbl_addr];
        tbl_b <= tab_b[tbl_addr];
    end

    // Datapath responder: ack ack_delay cycles after an issue pulse.
    int dp_cnt = 0;
    logic [AW-1:0] resp_sel = '0;
    initial begin
        sp_out_valid = 1'b0;
        sp_fx = '0;
        sp_fy = '0;
    end
    always @(negedge clk_in) begin
        if (sp_out_valid) sp_out_valid = 1'b0;
        if (dp_cnt > 0) begin
            dp_cnt--;
            if (dp_cnt == 0) begin
                sp_out_valid = 1'b1;
                sp_fx = resp_fx[resp_sel];
                sp_fy = resp_fy[resp_sel];
            end
        end
        if (sp_in_valid === 1'b1) begin
            dp_cnt = ack_delay;
            resp_sel = tbl_addr;
        end
    end

    // Event monitor: issue/done counts and operand stability while waiting.
    int issue_total = 0;
    int done_total = 0;
    int chg_total = 0;
    bit win = 1'b0;
    logic [63:0] ops_i;
    always @(posedge clk_in) begin
        #1;
        if (sp_in_valid === 1'b1) begin
            issue_total++;
            win = 1'b1;
            ops_i = {sp_p1, sp_p2, sp_v1, sp_v2};
        end else if (win) begin
            if ({sp_p1, sp_p2, sp_v1, sp_v2} !== ops_i) chg_total++;
            if (sp_out_valid === 1'b1) win = 1'b0;
        end
        if (done === 1'b1) done_total++;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] fx_of(input int n);
        logic signed [FS-1:0] t;
        t = force_x_flat[n*FS +: FS];
        return t;
    endfunction

    function automatic logic signed [31:0] fy_of(input int n);
        logic signed [FS-1:0] t;
        t = force_y_flat[n*FS +: FS];
        return t;
    endfunction

    task automatic set_spring(input int k, input int a, input int b,
                              input int fx, input int fy);
        tab_a[k]   = IW'(a);
        tab_b[k]   = IW'(b);
        resp_fx[k] = FS'(fx);
        resp_fy[k] = FS'(fy);
    endtask

    // Pulse start (called at a negedge in IDLE), count cycles to done, and
    // optionally re-pulse start at cycle poke_cyc. Returns in IDLE.
    task automatic run_pass(input int poke_cyc, output int done_cyc, output int busy_cnt);
        done_cyc = 0;
        busy_cnt = 0;
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
            start = (c == poke_cyc);
            @(negedge clk_in);
        end
        start = 1'b0;
        @(negedge clk_in);
    endtask

    initial begin
        int dc, bc, i0, d0, c0;
        rst_in = 1'b1;
        start  = 1'b0;
        for (int n = 0; n < NN; n++) begin
            pos_x_flat[n*PS +: PS] = PS'(n*3 + 1);
            pos_y_flat[n*PS +: PS] = PS'(100 - n*7);
            vel_x_flat[n*VS +: VS] = VS'(n*2 + 50);
            vel_y_flat[n*VS +: VS] = VS'(n + 40);
        end
        set_spring(3, 0, 0, 0, 0);
        set_spring(0, 0, 1, 5, -3);
        set_spring(1, 5, 5, 0, 0);
        set_spring(2, 5, 5, 0, 0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx_err", idx_err, 0);
        chk("rst_tbl_addr", tbl_addr, 0);
        chk("rst_sp_in_valid", sp_in_valid, 0);
        chk("rst_sp_p1", sp_p1, 0);
        chk("rst_fx0", fx_of(0), 0);
        chk("rst_fy9", fy_of(9), 0);

        // Scenario 1: single valid spring (0,1) plus two self-skips
        i0 = issue_total;
        run_pass(0, dc, bc);
        chk("s1_cycles", dc, 11);
        chk("s1_busy", bc, 10);
        chk("s1_issues", issue_total - i0, 1);
        chk("s1_fx0", fx_of(0), 5);
        chk("s1_fy0", fy_of(0), -3);
        chk("s1_fx1", fx_of(1), -5);
        chk("s1_fy1", fy_of(1), 3);
        chk("s1_fx2", fx_of(2), 0);
        chk("s1_idx_err", idx_err, 0);

        // Scenario 2: shared nodes in a ring
        set_spring(0, 0, 1, 2, 1);
        set_spring(1, 1, 2, 2, 2);
        set_spring(2, 2, 0, 2, 4);
        i0 = issue_total;
        run_pass(0, dc, bc);
        chk("s2_cycles", dc, 17);
        chk("s2_issues", issue_total - i0, 3);
        chk("s2_fx0", fx_of(0), 0);
        chk("s2_fx1", fx_of(1), 0);
        chk("s2_fx2", fx_of(2), 0);
        chk("s2_fy0", fy_of(0), -3);
        chk("s2_fy1", fy_of(1), 1);
        chk("s2_fy2", fy_of(2), 2);

        // Scenario 3: self-pair and out-of-range skips
        set_spring(0, 3, 3, 9, 9);
        set_spring(1, 0, 12, 9, 9);
        set_spring(2, 10, 2, 9, 9);
        i0 = issue_total;
        run_pass(0, dc, bc);
        chk("s3_cycles", dc, 8);
        chk("s3_busy", bc, 7);
        chk("s3_issues", issue_total - i0, 0);
        chk("s3_idx_err", idx_err, 1);
        chk("s3_fy0_cleared", fy_of(0), 0);
        chk("s3_fy2_cleared", fy_of(2), 0);

        // Scenario 4: accumulator overflow and negation of the minimum
        set_spring(0, 0, 1, 100, 0);
        set_spring(1, 0, 1, 100, 0);
        set_spring(2, 2, 3, -128, 0);
        run_pass(0, dc, bc);
        chk("s4_cycles", dc, 17);
        chk("s4_idx_err_cleared", idx_err, 0);
        chk("s4_fx2", fx_of(2), -128);
`ifdef SPRING_FORCE_SAT_EN
        chk("s4_fx0", fx_of(0), 127);
        chk("s4_fx1", fx_of(1), -128);
        chk("s4_fx3", fx_of(3), 127);
`else
        chk("s4_fx0", fx_of(0), -56);
        chk("s4_fx1", fx_of(1), 56);
        chk("s4_fx3", fx_of(3), -128);
`endif

        // Scenario 5: slow datapath, start pulsed during WAIT
        set_spring(0, 4, 6, 7, -9);
        set_spring(1, 5, 5, 0, 0);
        set_spring(2, 5, 5, 0, 0);
        ack_delay = 4;
        d0 = done_total;
        c0 = chg_total;
        run_pass(5, dc, bc);
        repeat (6) @(negedge clk_in);
        chk("s5_cycles", dc, 14);
        chk("s5_busy", bc, 13);
        chk("s5_done_pulses", done_total - d0, 1);
        chk("s5_operand_changes", chg_total - c0, 0);
        chk("s5_idle_busy", busy, 0);
        chk("s5_sp_p1", sp_p1, 32'h480D);
        chk("s5_sp_p2", sp_p2, 32'h3A13);
        chk("s5_sp_v1", sp_v1, 32'h2C3A);
        chk("s5_sp_v2", sp_v2, 32'h2E3E);
        chk("s5_fx4", fx_of(4), 7);
        chk("s5_fy4", fy_of(4), -9);
        chk("s5_fx6", fx_of(6), -7);
        chk("s5_fy6", fy_of(6), 9);

        // Scenario 6: reset during WAIT, late ack, then a clean pass
        set_spring(0, 0, 1, 5, -3);
        d0 = done_total;
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        repeat (4) @(negedge clk_in);
        chk("s6_busy_in_wait", busy, 1);
        rst_in = 1'b1;
        #1;
        chk("s6_busy_async", busy, 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (8) @(negedge clk_in);
        chk("s6_busy_after", busy, 0);
        chk("s6_fx0", fx_of(0), 0);
        chk("s6_fx4", fx_of(4), 0);
        chk("s6_sp_p1", sp_p1, 0);
        chk("s6_no_done", done_total - d0, 0);
        ack_delay = 1;
        run_pass(0, dc, bc);
        chk("s6_rerun_cycles", dc, 11);
        chk("s6_rerun_fx0", fx_of(0), 5);
        chk("s6_rerun_fy1", fy_of(1), 3);
        chk("s6_rerun_fx4", fx_of(4), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
